// File: rtl/cpu_types_pkg.sv
// Shared core types: RAM handshake states, machine word and memory-arbiter FSM states.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear; sat flags that MAX has been reached.
module starve_counter #(
  parameter int MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic sat
);
  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt;

  assign sat = (cnt == W'(MAX));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and MEM-stage data access.
// Optional access timeout is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  input  ramstate_t ramstate,
  input  word_t     ramload,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  output logic      mem_err,
  output logic      timeout,
  output logic      timeout_seen
);
  arb_state_t state, nxt;
  word_t      lat_addr, lat_store;
  logic       lat_wr;
  logic       dreq, gnt_i, gnt_d, req_g, ram_ack, ack, tmo;
  logic       starved, start_i, start_d;

  assign dreq    = dREN | dWEN;
  assign gnt_i   = (state == GNT_I);
  assign gnt_d   = (state == GNT_D);
  assign req_g   = (gnt_i & iREN) | (gnt_d & dreq);
  assign ram_ack = (ramstate == ACCESS) | (ramstate == ERROR);
  assign ack     = ram_ack | tmo;

  // Data normally wins; a fetch that has waited out STARVE_LIMIT data grants is forced in.
  assign start_i = (state == IDLE) & iREN & (starved | ~dreq);
  assign start_d = (state == IDLE) & dreq & ~(iREN & starved);

  starve_counter #(.MAX(STARVE_LIMIT)) u_starve (
    .CLK (CLK),
    .RST (RST),
    .clr (~iREN | start_i),
    .inc (start_d & iREN),
    .sat (starved)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (start_i)      nxt = GNT_I;
        else if (start_d) nxt = GNT_D;
      end
      GNT_I, GNT_D: if (!req_g || ack) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lat_addr  <= '0;
      lat_store <= '0;
      lat_wr    <= 1'b0;
    end else if (start_i) begin
      lat_addr  <= iaddr;
      lat_wr    <= 1'b0;
    end else if (start_d) begin
      lat_addr  <= daddr;
      lat_store <= dstore;
      lat_wr    <= dWEN;
    end
  end

  // Enables are gated by the live request so an abort releases the RAM at once.
  assign ramREN   = (gnt_i & iREN) | (gnt_d & dreq & ~lat_wr);
  assign ramWEN   = gnt_d & dreq & lat_wr;
  assign ramaddr  = (gnt_i | gnt_d) ? lat_addr : '0;
  assign ramstore = gnt_d ? lat_store : '0;

  assign iwait   = iREN & ~(gnt_i & ack);
  assign dwait   = dreq & ~(gnt_d & ack);
  assign iload   = (gnt_i & iREN & (ramstate == ACCESS)) ? ramload : '0;
  assign dload   = (gnt_d & dreq & ~lat_wr & (ramstate == ACCESS)) ? ramload : '0;
  assign mem_err = req_g & (ramstate == ERROR);
  assign timeout = tmo;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TW-1:0] gcnt;
  logic          seen;

  // gcnt counts completed grant cycles; it restarts from 0 on every grant entry.
  assign tmo          = req_g & ~ram_ack & (gcnt == TW'(TIMEOUT_CYCLES));
  assign timeout_seen = seen;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gcnt <= '0;
      seen <= 1'b0;
    end else begin
      if (state == IDLE) gcnt <= '0;
      else               gcnt <= gcnt + 1'b1;
      if (tmo) seen <= 1'b1;
    end
  end
`else
  assign tmo          = 1'b0;
  assign timeout_seen = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle check against a transaction-level model plus literal checks.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SL = 4;
  localparam int TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic      CLK = 1'b0;
  logic      RST = 1'b1;
  logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  word_t     iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  ramstate_t ramstate = FREE;
  logic      iwait, dwait, ramREN, ramWEN, mem_err, timeout, timeout_seen;
  word_t     iload, dload, ramaddr, ramstore;

  mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .mem_err(mem_err), .timeout(timeout), .timeout_seen(timeout_seen)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the RAM (0 none, 1 fetch, 2 data), what was captured, and the counters.
  int    own = 0;
  word_t m_addr = '0, m_store = '0;
  bit    m_wr = 1'b0;
  int    m_starve = 0, m_gcnt = 0;
  bit    m_seen = 1'b0;

  function automatic bit cur_req();
    return (own == 1) ? iREN : (own == 2) ? (dREN | dWEN) : 1'b0;
  endfunction

  function automatic bit ram_done();
    return (ramstate == ACCESS) || (ramstate == ERROR);
  endfunction

  function automatic bit cur_tmo();
    return TO_EN && own != 0 && cur_req() && !ram_done() && m_gcnt == TO;
  endfunction

  always @(posedge CLK or posedge RST) begin : model
    int n_own, n_starve, n_gcnt;
    bit tm;
    if (RST) begin
      own <= 0; m_addr <= '0; m_store <= '0; m_wr <= 1'b0;
      m_starve <= 0; m_gcnt <= 0; m_seen <= 1'b0;
    end else begin
      n_own = own; n_starve = m_starve; n_gcnt = m_gcnt;
      tm = cur_tmo();
      if (own == 0) begin
        n_gcnt = 0;
        if (iREN && (m_starve == SL || !(dREN || dWEN))) begin
          n_own = 1; m_addr <= iaddr; n_starve = 0;
        end else if (dREN || dWEN) begin
          n_own = 2; m_addr <= daddr; m_store <= dstore; m_wr <= dWEN;
          if (iREN && n_starve < SL) n_starve = n_starve + 1;
        end
      end else if (!cur_req() || ram_done() || tm) n_own = 0;
      else n_gcnt = n_gcnt + 1;
      if (!iREN) n_starve = 0;
      if (tm) m_seen <= 1'b1;
      own <= n_own; m_starve <= n_starve; m_gcnt <= n_gcnt;
    end
  end

  always @(negedge CLK) begin : cmp
    bit rq, tm, ak_i, ak_d;
    rq   = cur_req();
    tm   = cur_tmo();
    ak_i = own == 1 && (ram_done() || tm);
    ak_d = own == 2 && (ram_done() || tm);
    chk("m_ramREN",   ramREN,   (own == 1 && iREN) || (own == 2 && rq && !m_wr));
    chk("m_ramWEN",   ramWEN,   own == 2 && rq && m_wr);
    chk("m_ramaddr",  ramaddr,  own != 0 ? m_addr : 32'h0);
    chk("m_ramstore", ramstore, own == 2 ? m_store : 32'h0);
    chk("m_iwait",    iwait,    iREN && !ak_i);
    chk("m_dwait",    dwait,    (dREN || dWEN) && !ak_d);
    chk("m_iload",    iload,    (own == 1 && iREN && ramstate == ACCESS) ? ramload : 32'h0);
    chk("m_dload",    dload,    (own == 2 && rq && !m_wr && ramstate == ACCESS) ? ramload : 32'h0);
    chk("m_mem_err",  mem_err,  rq && ramstate == ERROR);
    chk("m_timeout",  timeout,  tm);
    chk("m_seen",     timeout_seen, m_seen);
  end

  // Grant-order log built from the acks the DUT actually gives.
  bit  log_en = 1'b0;
  byte seq[$];
  always @(negedge CLK) begin
    if (log_en) begin
      if (iREN && !iwait)           seq.push_back("I");
      if ((dREN || dWEN) && !dwait) seq.push_back("D");
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  initial begin
    string s;
    // reset: outputs idle, waits follow requests
    iREN = 1'b1;
    neg();
    chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 0); chk("rst_ramREN", ramREN, 0);
    chk("rst_ramaddr", ramaddr, 0); chk("rst_iload", iload, 0); chk("rst_seen", timeout_seen, 0);
    step(); iREN = 1'b0; dREN = 1'b1; neg(); chk("rst_dwait2", dwait, 1);
    step(); dREN = 1'b0; RST = 1'b0; neg();

    // fetch only
    step(); iREN = 1'b1; iaddr = 32'h40; ramstate = FREE; neg();
    chk("f_c0_ramREN", ramREN, 0); chk("f_c0_iwait", iwait, 1);
    step(); ramstate = BUSY; iaddr = 32'h44; neg();
    chk("f_c1_ramREN", ramREN, 1); chk("f_c1_addr", ramaddr, 32'h40); chk("f_c1_iwait", iwait, 1);
    step(); ramstate = ACCESS; ramload = 32'h8C220004; neg();
    chk("f_c2_iwait", iwait, 0); chk("f_c2_iload", iload, 32'h8C220004);
    step(); iREN = 1'b0; ramstate = FREE; neg();
    chk("f_c3_idle_addr", ramaddr, 0);

    // simultaneous fetch and write: data first, then fetch
    step(); iREN = 1'b1; iaddr = 32'h60; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; neg();
    chk("s_c0_ramWEN", ramWEN, 0);
    step(); ramstate = ACCESS; daddr = 32'h104; neg();
    chk("s_c1_ramWEN", ramWEN, 1); chk("s_c1_addr", ramaddr, 32'h100);
    chk("s_c1_store", ramstore, 32'hDEADBEEF); chk("s_c1_dwait", dwait, 0); chk("s_c1_iwait", iwait, 1);
    step(); dWEN = 1'b0; ramstate = FREE; neg();
    chk("s_c2_ramREN", ramREN, 0);
    step(); ramstate = ACCESS; ramload = 32'h11; neg();
    chk("s_c3_ramREN", ramREN, 1); chk("s_c3_addr", ramaddr, 32'h60); chk("s_c3_iload", iload, 32'h11);
    step(); iREN = 1'b0; ramstate = FREE; neg();

    // starvation: six acks with both requests held
    step(); iREN = 1'b1; dREN = 1'b1; daddr = 32'h300; ramstate = ACCESS; ramload = 32'hA5; log_en = 1'b1;
    repeat (12) neg();
    step(); log_en = 1'b0; iREN = 1'b0; dREN = 1'b0; ramstate = FREE; neg();
    s = "";
    foreach (seq[k]) s = {s, string'(seq[k])};
    total++;
    if (s != "DDDDID") begin
      bad++;
      $display("FAIL starve_order: got %s want DDDDID", s);
    end

    // abort while BUSY, then ERROR on a fetch
    step(); dREN = 1'b1; daddr = 32'h200; ramstate = BUSY; ramload = 32'h77; neg();
    chk("a_c0_ramREN", ramREN, 0);
    step(); neg();
    chk("a_c1_ramREN", ramREN, 1); chk("a_c1_addr", ramaddr, 32'h200); chk("a_c1_dwait", dwait, 1);
    step(); dREN = 1'b0; neg();
    chk("a_c2_ramREN", ramREN, 0); chk("a_c2_dwait", dwait, 0); chk("a_c2_dload", dload, 0);
    step(); iREN = 1'b1; iaddr = 32'h90; ramstate = FREE; neg();
    chk("a_c3_ramREN", ramREN, 0);
    step(); ramstate = ERROR; ramload = 32'h12345678; neg();
    chk("e_ramREN", ramREN, 1); chk("e_addr", ramaddr, 32'h90); chk("e_mem_err", mem_err, 1);
    chk("e_iwait", iwait, 0); chk("e_iload", iload, 0);
    step(); iREN = 1'b0; ramstate = FREE; neg();
    chk("e_mem_err_off", mem_err, 0);

    // timeout (if built) while BUSY, then reset mid-grant
    step(); iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY; neg();
    repeat (8) begin step(); neg(); end
    chk("t_c8_timeout", timeout, 0); chk("t_c8_iwait", iwait, 1);
    step(); neg();
`ifdef MEM_ARB_TIMEOUT_EN
    chk("t_c9_timeout", timeout, 1); chk("t_c9_iwait", iwait, 0); chk("t_c9_iload", iload, 0);
    step(); neg();
    chk("t_c10_timeout", timeout, 0); chk("t_c10_seen", timeout_seen, 1); chk("t_c10_idle", ramaddr, 0);
`else
    chk("t_c9_timeout", timeout, 0); chk("t_c9_iwait", iwait, 1);
    step(); neg();
    chk("t_c10_seen", timeout_seen, 0); chk("t_c10_ramREN", ramREN, 1);
`endif
    step(); neg();
    chk("t_c11_ramREN", ramREN, 1);
    #2 RST = 1'b1; #1;
    chk("r_ramREN", ramREN, 0); chk("r_seen", timeout_seen, 0);
    chk("r_iwait", iwait, 1); chk("r_addr", ramaddr, 0);
    step(); iREN = 1'b0; neg();
    step(); RST = 1'b0; neg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing the single-ported unified RAM between the instruction-fetch port and the MEM-stage data port of the pipelined core. It registers one grant at a time, drives the RAM while that grant is held and returns load data and wait status to each requester. It sits between the IF/MEM stages and the RAM model. It also adds anti-starvation for instruction fetch and optional access-timeout detection.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending, before the fetch is forced.
- TIMEOUT_CYCLES, 255: grant cycles without a RAM response before timeout (used only with MEM_ARB_TIMEOUT_EN).
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; one clock; reset is asynchronous and active-high.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  instruction word address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  write data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- ramload  in  32  RAM read data.
- iwait  out  1  fetch not yet served.
- dwait  out  1  data access not yet served.
- iload  out  32  fetched word; valid while iwait low.
- dload  out  32  read data; valid while dwait low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- mem_err  out  1  one-cycle pulse on RAM ERROR.
- timeout  out  1  one-cycle pulse on access timeout.
- timeout_seen  out  1  sticky; set by timeout, cleared only by reset.

## Operation
- The FSM has three states: IDLE, GNT_I and GNT_D.
- IDLE:
  - Winner is data when dREN|dWEN, else fetch.
  - Exception: when the starvation counter equals STARVE_LIMIT and iREN is high, fetch wins.
  - The winner's address and store data are latched. The next state is GNT_I or GNT_D.
- GNT_D:
  - ramaddr and ramstore come from the latched values.
  - ramWEN is driven by the latched write type. ramREN is driven by the latched read type.
  - dWEN takes precedence when dREN and dWEN are both high: the access is a write.
- GNT_I: ramREN=1 and ramaddr = latched iaddr.
- RAM ACCESS while granted:
  - The granted wait goes low in that same cycle. The granted load equals ramload for a read.
  - The next state is IDLE.
- RAM ERROR while granted: same as ACCESS, except the load is 0 and mem_err pulses.
- FREE or BUSY: hold the grant.
- Abort: the requester drops its request while granted.
  - RAM enables drop combinationally.
  - The next state is IDLE and no ack is given.
- Starvation counter:
  - Increments on each data grant issued while iREN is high. It saturates at STARVE_LIMIT.
  - Cleared on any fetch grant, or whenever iREN is low.
- Wait outputs:
  - iwait = iREN & ~(GNT_I & ack); dwait = (dREN|dWEN) & ~(GNT_D & ack).
  - ack means ramstate is ACCESS or ERROR (or a timeout).
  - Both are therefore combinational from the requests and are never low without a request.

## Timing
- Reset values: state IDLE, counters 0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0, mem_err=0, timeout=0, timeout_seen=0.
- During reset, iwait and dwait follow their request inputs.
- Reset asserted mid-grant: RAM enables drop immediately (asynchronously). The access is lost.
- Minimum latency: request in cycle 0, grant active in cycle 1, ACCESS in cycle 1 gives wait low in cycle 1. Back-to-back grants are therefore every 2 cycles.
- The next request is arbitrated only in IDLE. A request arriving during a grant waits.
- Latched address and data are immune to changes on daddr/iaddr during the grant.
- Load outputs are 0 whenever the matching wait is high.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - An 8+ bit grant-cycle counter runs. It is cleared on entering a grant.
  - When the counter reaches TIMEOUT_CYCLES without ACCESS or ERROR:
    - timeout pulses and timeout_seen sets.
    - The granted wait drops for one cycle, with load 0.
    - The FSM returns to IDLE.
- Undefined: no counter; a grant is held indefinitely. timeout and timeout_seen are tied 0. The ports remain.

## Structure
- cpu_types_pkg holds ramstate_t (FREE=0, BUSY=1, ACCESS=2, ERROR=3), word_t (32-bit) and the arbiter state enum arb_state_t.
- Sub-module starve_counter: saturating counter with clear, used for the anti-starvation count.
- Everything else is a single module.

## Test plan
- Fetch only:
  - Stimulus: iREN=1, iaddr=0x40; RAM returns ACCESS on the 2nd grant cycle with ramload=0x8C220004.
  - Response: ramREN=1 from cycle 1, iwait low in cycle 2, iload=0x8C220004, FSM back in IDLE in cycle 3.
- Simultaneous requests:
  - Stimulus: iREN and dWEN high, daddr=0x100, dstore=0xDEADBEEF.
  - Response: data is served first (ramWEN=1, ramaddr=0x100); the fetch is granted next.
- Starvation:
  - Stimulus: dREN held high for 6 accesses while iREN is high, STARVE_LIMIT=4.
  - Response: grants are D, D, D, D, I, D.
- Abort: drop dREN mid-grant while RAM is BUSY. Response: ramREN drops in the same cycle, no dload, IDLE next cycle.
- ERROR:
  - Stimulus: ramstate=ERROR during GNT_I.
  - Response: mem_err pulses once, iwait low, iload=0.
- Timeout and reset:
  - With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, hold BUSY. Response: timeout pulses after 8 grant cycles and timeout_seen=1.
  - Then assert RST mid-grant. Response: ramREN=0 immediately and timeout_seen=0.
